// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS control unit.
// Optional feature macro: JAL_SUPPORT_EN (adds the JAL_WB state for opcode 000011).
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned SEL_W   = 2;

  // Opcode and funct values
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] FN_JR    = 6'b001000;

  // ALUOp codes seen by the ALU control decoder
  localparam logic [ALUOP_W-1:0] ALUOP_LW   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_BEQ  = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_BNE  = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_LUI  = 3'b011;
  localparam logic [ALUOP_W-1:0] ALUOP_ADDI = 3'b100;
  localparam logic [ALUOP_W-1:0] ALUOP_ORI  = 3'b101;
  localparam logic [ALUOP_W-1:0] ALUOP_SW   = 3'b110;
  localparam logic [ALUOP_W-1:0] ALUOP_R    = 3'b111;

  // Mux select codes
  localparam logic [SEL_W-1:0] SRCB_RT       = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR     = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM      = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2  = 2'b11;
  localparam logic [SEL_W-1:0] PCSRC_ALU     = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT  = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP    = 2'b10;
  localparam logic [SEL_W-1:0] PCSRC_RS      = 2'b11;
  localparam logic [SEL_W-1:0] REGDST_RT     = 2'b00;
  localparam logic [SEL_W-1:0] REGDST_RD     = 2'b01;
  localparam logic [SEL_W-1:0] REGDST_RA     = 2'b10;
  localparam logic [SEL_W-1:0] M2R_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] M2R_MDR       = 2'b01;
  localparam logic [SEL_W-1:0] M2R_PC        = 2'b10;

  // State encodings (visible on state_dbg)
  typedef enum logic [STATE_W-1:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_WB_R     = 4'd7,
    ST_WB_I     = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_JUMP_REG = 4'd12,
`ifdef JAL_SUPPORT_EN
    ST_JAL_WB   = 4'd13,
`endif
    ST_TRAP     = 4'd14
  } state_e;

  // Control word produced for every state
  typedef struct packed {
    logic               mem_read;
    logic               mem_write;
    logic               i_or_d;
    logic               ir_write;
    logic               pc_write;
    logic               reg_write;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src_a;
    logic [SEL_W-1:0]   alu_src_b;
    logic [SEL_W-1:0]   pc_source;
    logic [SEL_W-1:0]   reg_dst;
    logic [SEL_W-1:0]   mem_to_reg;
  } ctrl_word_t;

endpackage

// File: rtl/multicycle_control_ctrl_output_decoder.sv
// Combinational state-to-control-word decode for the multicycle control FSM.
module ctrl_output_decoder
  import mips_ctrl_pkg::*;
(
  input  state_e          i_state,
  input  logic [OP_W-1:0] i_opcode,
  input  logic [OP_W-1:0] i_funct,
  input  logic            i_zero,
  input  logic            i_mem_ready,
  output ctrl_word_t      o_ctrl
);

  // Moore decode; memory handshakes qualify the IR/PC enables in FETCH
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADDI;
        if (i_mem_ready) begin
          o_ctrl.ir_write  = 1'b1;
          o_ctrl.pc_write  = 1'b1;
          o_ctrl.pc_source = PCSRC_ALU;
        end
      end
      ST_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.alu_op    = ALUOP_ADDI;
      end
      ST_EXEC_R: begin
        if (i_funct != FN_JR) begin
          o_ctrl.alu_src_a = 1'b1;
          o_ctrl.alu_src_b = SRCB_RT;
          o_ctrl.alu_op    = ALUOP_R;
        end
      end
      ST_EXEC_I: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        case (i_opcode)
          OP_ORI:  o_ctrl.alu_op = ALUOP_ORI;
          OP_LUI:  o_ctrl.alu_op = ALUOP_LUI;
          default: o_ctrl.alu_op = ALUOP_ADDI;
        endcase
      end
      ST_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = (i_opcode == OP_SW) ? ALUOP_SW : ALUOP_LW;
      end
      ST_MEM_RD: begin
        o_ctrl.i_or_d   = 1'b1;
        o_ctrl.mem_read = 1'b1;
      end
      ST_MEM_WR: begin
        o_ctrl.i_or_d    = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      ST_WB_R: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = REGDST_RD;
        o_ctrl.mem_to_reg = M2R_ALUOUT;
      end
      ST_WB_I: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = REGDST_RT;
        o_ctrl.mem_to_reg = M2R_ALUOUT;
      end
      ST_WB_MEM: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = REGDST_RT;
        o_ctrl.mem_to_reg = M2R_MDR;
      end
      ST_BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RT;
        o_ctrl.pc_source = PCSRC_ALUOUT;
        if (i_opcode == OP_BNE) begin
          o_ctrl.alu_op   = ALUOP_BNE;
          o_ctrl.pc_write = ~i_zero;
        end else begin
          o_ctrl.alu_op   = ALUOP_BEQ;
          o_ctrl.pc_write = i_zero;
        end
      end
      ST_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      ST_JUMP_REG: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_RS;
      end
`ifdef JAL_SUPPORT_EN
      ST_JAL_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = REGDST_RA;
        o_ctrl.mem_to_reg = M2R_PC;
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
      end
`endif
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, next-state logic and reset-gated outputs.
// Optional feature macro: JAL_SUPPORT_EN (JAL via the JAL_WB state; otherwise JAL traps).
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src_a,
  output logic [SEL_W-1:0]   alu_src_b,
  output logic [SEL_W-1:0]   pc_source,
  output logic [SEL_W-1:0]   reg_dst,
  output logic [SEL_W-1:0]   mem_to_reg,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_e     r_state;
  state_e     w_next_state;
  logic       r_illegal_op;
  ctrl_word_t w_ctrl;
  ctrl_word_t w_out;

  // State register and sticky illegal-opcode flag; reset wins over any transition
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_FETCH;
      r_illegal_op <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state == ST_TRAP) begin
        r_illegal_op <= 1'b1;
      end
    end
  end

  // Next-state selection
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH:    if (mem_ready) w_next_state = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:               w_next_state = ST_EXEC_R;
          OP_ADDI, OP_ORI, OP_LUI: w_next_state = ST_EXEC_I;
          OP_LW, OP_SW:           w_next_state = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:         w_next_state = ST_BRANCH;
          OP_J:                   w_next_state = ST_JUMP;
`ifdef JAL_SUPPORT_EN
          OP_JAL:                 w_next_state = ST_JAL_WB;
`endif
          default:                w_next_state = ST_TRAP;
        endcase
      end
      ST_EXEC_R:   w_next_state = (funct == FN_JR) ? ST_JUMP_REG : ST_WB_R;
      ST_EXEC_I:   w_next_state = ST_WB_I;
      ST_MEM_ADDR: w_next_state = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (mem_ready) w_next_state = ST_WB_MEM;
      ST_MEM_WR:   if (mem_ready) w_next_state = ST_FETCH;
      ST_TRAP:     w_next_state = ST_TRAP;
      default:     w_next_state = ST_FETCH;
    endcase
  end

  ctrl_output_decoder u_decoder (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_funct     (funct),
    .i_zero      (zero),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // Output stage: strobes forced low while reset is held
  always_comb begin
    w_out = w_ctrl;
    if (reset) begin
      w_out.mem_read  = 1'b0;
      w_out.mem_write = 1'b0;
      w_out.ir_write  = 1'b0;
      w_out.pc_write  = 1'b0;
      w_out.reg_write = 1'b0;
    end
  end

  assign mem_read   = w_out.mem_read;
  assign mem_write  = w_out.mem_write;
  assign i_or_d     = w_out.i_or_d;
  assign ir_write   = w_out.ir_write;
  assign pc_write   = w_out.pc_write;
  assign reg_write  = w_out.reg_write;
  assign alu_op     = w_out.alu_op;
  assign alu_src_a  = w_out.alu_src_a;
  assign alu_src_b  = w_out.alu_src_b;
  assign pc_source  = w_out.pc_source;
  assign reg_dst    = w_out.reg_dst;
  assign mem_to_reg = w_out.mem_to_reg;
  assign illegal_op = r_illegal_op;
  assign state_dbg  = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction step lists built from the
// instruction-level rules are queued by the driver and checked cycle by cycle by a monitor.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       mrd, mwr, iord, irw, pcw, rgw;
    logic [2:0] aop;
    logic       sa;
    logic [1:0] sb, ps, rd, m2r;
    logic       ill;
  } exp_t;

  typedef enum int {K_ADD, K_SUB, K_JR, K_ADDI, K_ORI, K_LUI, K_LW, K_SW,
                    K_BEQ, K_BNE, K_J, K_JAL, K_BAD} kind_e;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_source, reg_dst, mem_to_reg;
  logic       illegal_op;
  logic [3:0] state_dbg;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  // Monitor: one expected control word per cycle, sampled mid-cycle
  exp_t  mon_e, mon_a;
  string mon_t;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a = {state_dbg, mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write,
               alu_op, alu_src_a, alu_src_b, pc_source, reg_dst, mem_to_reg, illegal_op};
      n_vec++;
      if (mon_a !== mon_e) begin
        n_err++;
        $display("FAIL %s: actual state=%0d word=%h, required state=%0d word=%h",
                 mon_t, mon_a.st, mon_a, mon_e.st, mon_e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [3:0] st);
    mk = '0;
    mk.st = st;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    legal = (op == 6'b000000) || (op == 6'b001000) || (op == 6'b001101) ||
            (op == 6'b001111) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) || (op == 6'b000101) || (op == 6'b000010);
`ifdef JAL_SUPPORT_EN
    if (op == 6'b000011) legal = 1'b1;
`endif
  endfunction

  task automatic step(input exp_t e, input string tag, input logic rdy);
    mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic trap_and_reset(input int n);
    exp_t e;
    e = mk(4'(ST_TRAP));
    e.ill = 1'b1;
    for (int i = 0; i < n; i++) step(e, "trap_hold", 1'($urandom_range(0, 1)));
    reset = 1'b1;
    step(e, "trap_reset", 1'($urandom_range(0, 1)));
    reset = 1'b0;
  endtask

  task automatic fetch_decode(input int fst);
    exp_t e;
    e = mk(4'(ST_FETCH));
    e.mrd = 1'b1; e.sb = 2'b01; e.aop = 3'b100;
    for (int i = 0; i < fst; i++) step(e, "fetch_stall", 1'b0);
    e.irw = 1'b1; e.pcw = 1'b1;
    step(e, "fetch", 1'b1);
    e = mk(4'(ST_DECODE));
    e.sb = 2'b11; e.aop = 3'b100;
    step(e, "decode", 1'($urandom_range(0, 1)));
  endtask

  task automatic run_instr(input kind_e k, input int fst, input int mst,
                           input logic z, input logic [5:0] bad_op);
    exp_t e;
    funct = 6'($urandom_range(0, 63));
    zero  = z;
    case (k)
      K_ADD:  begin opcode = 6'b000000; funct = 6'b100000; end
      K_SUB:  begin opcode = 6'b000000;
                    while (funct == 6'b001000) funct = 6'($urandom_range(0, 63)); end
      K_JR:   begin opcode = 6'b000000; funct = 6'b001000; end
      K_ADDI: opcode = 6'b001000;
      K_ORI:  opcode = 6'b001101;
      K_LUI:  opcode = 6'b001111;
      K_LW:   opcode = 6'b100011;
      K_SW:   opcode = 6'b101011;
      K_BEQ:  opcode = 6'b000100;
      K_BNE:  opcode = 6'b000101;
      K_J:    opcode = 6'b000010;
      K_JAL:  opcode = 6'b000011;
      default: opcode = bad_op;
    endcase
    fetch_decode(fst);
    case (k)
      K_ADD, K_SUB: begin
        e = mk(4'(ST_EXEC_R)); e.sa = 1'b1; e.sb = 2'b00; e.aop = 3'b111;
        step(e, "exec_r", 1'($urandom_range(0, 1)));
        e = mk(4'(ST_WB_R)); e.rgw = 1'b1; e.rd = 2'b01;
        step(e, "wb_r", 1'($urandom_range(0, 1)));
      end
      K_JR: begin
        e = mk(4'(ST_EXEC_R));
        step(e, "exec_jr", 1'($urandom_range(0, 1)));
        e = mk(4'(ST_JUMP_REG)); e.pcw = 1'b1; e.ps = 2'b11;
        step(e, "jump_reg", 1'($urandom_range(0, 1)));
      end
      K_ADDI, K_ORI, K_LUI: begin
        e = mk(4'(ST_EXEC_I)); e.sa = 1'b1; e.sb = 2'b10;
        e.aop = (k == K_ADDI) ? 3'b100 : (k == K_ORI) ? 3'b101 : 3'b011;
        step(e, "exec_i", 1'($urandom_range(0, 1)));
        e = mk(4'(ST_WB_I)); e.rgw = 1'b1;
        step(e, "wb_i", 1'($urandom_range(0, 1)));
      end
      K_LW: begin
        e = mk(4'(ST_MEM_ADDR)); e.sa = 1'b1; e.sb = 2'b10; e.aop = 3'b000;
        step(e, "mem_addr_lw", 1'($urandom_range(0, 1)));
        e = mk(4'(ST_MEM_RD)); e.iord = 1'b1; e.mrd = 1'b1;
        for (int i = 0; i < mst; i++) step(e, "mem_rd_stall", 1'b0);
        step(e, "mem_rd", 1'b1);
        e = mk(4'(ST_WB_MEM)); e.rgw = 1'b1; e.m2r = 2'b01;
        step(e, "wb_mem", 1'($urandom_range(0, 1)));
      end
      K_SW: begin
        e = mk(4'(ST_MEM_ADDR)); e.sa = 1'b1; e.sb = 2'b10; e.aop = 3'b110;
        step(e, "mem_addr_sw", 1'($urandom_range(0, 1)));
        e = mk(4'(ST_MEM_WR)); e.iord = 1'b1; e.mwr = 1'b1;
        for (int i = 0; i < mst; i++) step(e, "mem_wr_stall", 1'b0);
        step(e, "mem_wr", 1'b1);
      end
      K_BEQ, K_BNE: begin
        e = mk(4'(ST_BRANCH)); e.sa = 1'b1; e.ps = 2'b01;
        e.aop = (k == K_BEQ) ? 3'b001 : 3'b010;
        e.pcw = (k == K_BEQ) ? z : ~z;
        step(e, (k == K_BEQ) ? "branch_beq" : "branch_bne", 1'($urandom_range(0, 1)));
      end
      K_J: begin
        e = mk(4'(ST_JUMP)); e.pcw = 1'b1; e.ps = 2'b10;
        step(e, "jump", 1'($urandom_range(0, 1)));
      end
      K_JAL: begin
`ifdef JAL_SUPPORT_EN
        e = mk(4'(ST_JAL_WB)); e.rgw = 1'b1; e.rd = 2'b10; e.m2r = 2'b10;
        e.pcw = 1'b1; e.ps = 2'b10;
        step(e, "jal_wb", 1'($urandom_range(0, 1)));
`else
        trap_and_reset(10);
`endif
      end
      default: trap_and_reset(10);
    endcase
  endtask

  // Store interrupted by reset while its memory access is stalled
  task automatic sw_reset(input int mst);
    exp_t e;
    opcode = 6'b101011; funct = 6'($urandom_range(0, 63)); zero = 1'b0;
    fetch_decode(0);
    e = mk(4'(ST_MEM_ADDR)); e.sa = 1'b1; e.sb = 2'b10; e.aop = 3'b110;
    step(e, "mem_addr_sw", 1'b1);
    e = mk(4'(ST_MEM_WR)); e.iord = 1'b1; e.mwr = 1'b1;
    for (int i = 0; i < mst; i++) step(e, "mem_wr_stall", 1'b0);
    reset = 1'b1;
    e.mwr = 1'b0;
    step(e, "mem_wr_reset", 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    exp_t e;
    kind_e k;
    logic [5:0] bop;
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    e = mk(4'(ST_FETCH)); e.sb = 2'b01; e.aop = 3'b100;
    step(e, "reset_fetch", 1'b1);
    reset = 1'b0;

    run_instr(K_ADD, 0, 0, 1'b0, 6'd0);
    run_instr(K_LW, 0, 2, 1'b0, 6'd0);
    run_instr(K_BEQ, 0, 0, 1'b1, 6'd0);
    run_instr(K_BNE, 0, 0, 1'b1, 6'd0);
    run_instr(K_BAD, 0, 0, 1'b0, 6'b111111);
    run_instr(K_JR, 0, 0, 1'b0, 6'd0);
    run_instr(K_JAL, 0, 0, 1'b0, 6'd0);
    sw_reset(2);
    run_instr(K_J, 1, 0, 1'b0, 6'd0);

    for (int n = 0; n < 150; n++) begin
      k = kind_e'($urandom_range(0, 12));
      bop = 6'($urandom_range(0, 63));
      while (legal(bop)) bop = 6'($urandom_range(0, 63));
      if (k == K_SW && $urandom_range(0, 3) == 0) sw_reset($urandom_range(0, 2));
      else run_instr(k, $urandom_range(0, 2), $urandom_range(0, 2),
                     1'($urandom_range(0, 1)), bop);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
